// File: rtl/search_mem_responder.sv
// search_mem_responder: loadable reference/search pixel memory that sequences one core run per loaded frame.
// Optional LOAD_ERR_EN enables load_last framing checks and the sticky load_err flag.
module search_mem_responder #(
   parameter int PIX_W   = 8,
   parameter int R_DEPTH = 256,
   parameter int S_DEPTH = 961,
   parameter int RA_W    = 8,
   parameter int SA_W    = 10
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [PIX_W-1:0] load_data,
   input  logic             load_last,
   input  logic [RA_W-1:0]  AddressR,
   input  logic [SA_W-1:0]  AddressS1,
   input  logic [SA_W-1:0]  AddressS2,
   output logic [PIX_W-1:0] R,
   output logic [PIX_W-1:0] S1,
   output logic [PIX_W-1:0] S2,
   output logic             start,
   input  logic             completed,
   output logic [7:0]       frame_cnt,
   output logic             load_err
);
   localparam int CW = (SA_W > RA_W) ? SA_W : RA_W;

   typedef enum logic [1:0] {LOAD_R, LOAD_S, RUN, DRAIN} state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic             beat, last_beat, err, wr_r, wr_s;
   logic [PIX_W-1:0] rmem [R_DEPTH];
   logic [PIX_W-1:0] smem [S_DEPTH];

   assign load_ready = (state == LOAD_R) || (state == LOAD_S);
   assign beat       = load_valid && load_ready;
   assign last_beat  = (state == LOAD_S) && (cnt == CW'(S_DEPTH - 1));

`ifdef LOAD_ERR_EN
   assign err = beat && (load_last != last_beat);
`else
   logic unused_last;
   assign unused_last = load_last;
   assign err         = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      wr_r     = 1'b0;
      wr_s     = 1'b0;
      if (err) begin
         state_nx = LOAD_R;
         cnt_nx   = '0;
      end else begin
         case (state)
            LOAD_R: if (beat) begin
               wr_r     = 1'b1;
               cnt_nx   = (cnt == CW'(R_DEPTH - 1)) ? '0 : cnt + 1'b1;
               state_nx = (cnt == CW'(R_DEPTH - 1)) ? LOAD_S : LOAD_R;
            end
            LOAD_S: if (beat) begin
               wr_s     = 1'b1;
               cnt_nx   = last_beat ? '0 : cnt + 1'b1;
               state_nx = last_beat ? RUN : LOAD_S;
            end
            RUN:     state_nx = completed ? DRAIN : RUN;
            default: state_nx = completed ? DRAIN : LOAD_R;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= LOAD_R;
         cnt       <= '0;
         start     <= 1'b0;
         frame_cnt <= '0;
         load_err  <= 1'b0;
         R         <= '0;
         S1        <= '0;
         S2        <= '0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         start    <= (state_nx == RUN);
         load_err <= load_err | err;
         if (state == RUN && completed)
            frame_cnt <= frame_cnt + 8'd1;
         // reads sample the pre-write contents, giving read-before-write on collisions
         R  <= rmem[AddressR];
         S1 <= (AddressS1 < SA_W'(S_DEPTH)) ? smem[AddressS1] : '0;
         S2 <= (AddressS2 < SA_W'(S_DEPTH)) ? smem[AddressS2] : '0;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_r)
         rmem[cnt[RA_W-1:0]] <= load_data;
      if (wr_s)
         smem[cnt[SA_W-1:0]] <= load_data;
   end
endmodule

// File: doc/search_mem_responder.md
Name: search_mem_responder

Overview:
- Memory-side responder for the motion-estimation core `top`.
- Accepts a reference block and a search window as one byte-stream load.
- Serves the core's `AddressR`/`AddressS1`/`AddressS2` read requests with registered pixel data.
- Drives `start` and watches `completed` to sequence one frame per load.
- Replaces the bench-only ROM models with a synthesizable, loadable responder.

Parameters:
- PIX_W, 8, pixel width in bits.
- R_DEPTH, 256, reference block size (16x16).
- S_DEPTH, 961, search window size (31x31).
- RA_W, 8, reference address width.
- SA_W, 10, search address width.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- load_valid  in  1  load beat valid.
- load_ready  out  1  responder accepts a load beat this cycle.
- load_data  in  PIX_W  load pixel.
- load_last  in  1  marks the final beat of a frame; used only with LOAD_ERR_EN.
- AddressR  in  RA_W  reference read address from the core.
- AddressS1  in  SA_W  search read address, port 1.
- AddressS2  in  SA_W  search read address, port 2.
- R  out  PIX_W  reference pixel.
- S1  out  PIX_W  search pixel, port 1.
- S2  out  PIX_W  search pixel, port 2.
- start  out  1  run request to the core.
- completed  in  1  core finished the search.
- frame_cnt  out  8  number of completed frames, wraps at 255 to 0.
- load_err  out  1  sticky load framing error.

Behaviour:
- Reset (async assert, sync deassert):
  - state=LOAD_R, load counter=0, load_ready=1, start=0.
  - R=S1=S2=0, frame_cnt=0, load_err=0.
  - Memory contents are not cleared.
- A beat transfers when load_valid && load_ready.
- States:
  - LOAD_R: load_ready=1. Each beat writes Rmem[cnt], cnt++. After beat R_DEPTH-1: cnt=0, go to LOAD_S.
  - LOAD_S: load_ready=1. Each beat writes Smem[cnt], cnt++. After beat S_DEPTH-1: cnt=0, go to RUN. Total frame = 1217 beats.
  - RUN: load_ready=0, start=1 (registered, first high cycle is the cycle after the final beat). When completed=1 is sampled: start=0 next cycle, frame_cnt++, go to DRAIN.
  - DRAIN: load_ready=0, start=0. Stays until completed=0 is sampled, then goes to LOAD_R. This prevents a stale `completed` from closing the next frame.
- `completed` is ignored outside RUN.
- Read ports:
  - Independent and always active, in every state.
  - Data is registered: address sampled at edge N, data valid after edge N+1 (1-cycle latency).
  - S1 and S2 may hit the same address; both return the same data.
  - Search address >= S_DEPTH (961..1023) returns 0.
  - A read and a load write to the same address in the same cycle return the old data (read-before-write).
  - Reads during LOAD return the current, possibly partially updated, contents.
- frame_cnt 255 -> 0 on the next completion; no flag.
- Reset mid-load abandons the partial frame; the next beat after reset is Rmem[0].
- Reset during RUN drops start immediately (async).

Optional Feature:
- Macro: LOAD_ERR_EN.
- When defined, load_last is checked on every accepted beat:
  - Error condition: load_last=1 on a beat other than the 1217th, or load_last=0 on the 1217th.
  - On error, the beat is discarded (not written), cnt=0, state=LOAD_R, load_err=1.
  - load_err stays set until reset; the failed frame never asserts start.
- When not defined, load_last is ignored and load_err is tied 0.

Test Plan:
- Reset, then stream 1217 beats, Rmem[i]=i, Smem[j]=j[7:0], load_valid held 1 -> load_ready falls after beat 1217; start=1 on the next cycle; frame_cnt=0.
- In RUN, drive AddressR=5, AddressS1=960, AddressS2=961 -> one cycle later R=5, S1=0xC0, S2=0.
- Hold start in RUN for 100 cycles, then pulse completed=1 for 3 cycles -> start=0 one cycle after first sample; frame_cnt=1; load_ready=1 only once completed=0.
- Assert reset_n=0 for 1 cycle after 100 load beats, reload a frame with Rmem[0]=0xAA -> AddressR=0 reads 0xAA; start asserts only after 1217 new beats.
- Run 256 frames back to back -> frame_cnt wraps to 0; start toggles once per frame.
- With LOAD_ERR_EN, assert load_last on beat 300 -> load_err=1, no start; the next clean 1217-beat frame runs normally; load_err stays 1.
